// File: rtl/siacore_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// siacore_scheduler_pkg
// Shared definitions for the Sia work scheduler: FSM state encodings, result
// status codes, nonce field location inside the 640-bit block header, and a
// byte-swap helper (the header nonce is stored little-endian).
// ---------------------------------------------------------------------------
package siacore_scheduler_pkg;

    localparam int WORK_W    = 640;
    localparam int NONCE_LSB = 256;
    localparam int NONCE_MSB = 287;

    // Wide enough for a core index with up to 8 cores.
    localparam int K_W = 3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_REPORT = 2'd3;

    localparam logic [1:0] RES_FOUND     = 2'b00;
    localparam logic [1:0] RES_EXHAUSTED = 2'b01;
    localparam logic [1:0] RES_TIMEOUT   = 2'b10;

    typedef struct packed {
        logic [31:0] nonce;
        logic [1:0]  status;
    } sched_result_t;

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage

// File: rtl/siacore_scheduler_found_arb.sv
// ---------------------------------------------------------------------------
// siacore_scheduler_found_arb
// Fixed-priority found picker, nonce mux and range-exhaustion tracker for the
// scheduler. The lowest-indexed core reporting a find wins. The done mask
// accumulates core_done pulses while tracking is enabled; all_done looks
// through the current cycle's pulses so the last done is acted on at once.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   clear         clear the done mask (RUN entry)
//   track         accumulate core_done into the mask (RUN only)
//   core_found    per-core found pulse
//   core_nonce    per-core nonce, core k at [32k+31:32k]
//   core_done     per-core range-exhausted pulse
//   found_any     at least one core_found bit set
//   found_nonce   nonce of the lowest-indexed finding core
//   all_done      mask (including this cycle's pulses) is all ones
// ---------------------------------------------------------------------------
module siacore_scheduler_found_arb #(
    parameter int NCORES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   track,
    input  logic [NCORES-1:0]      core_found,
    input  logic [NCORES*32-1:0]   core_nonce,
    input  logic [NCORES-1:0]      core_done,
    output logic                   found_any,
    output logic [31:0]            found_nonce,
    output logic                   all_done
);

    logic [NCORES-1:0] mask_q;

    // Scan from the top down so the lowest index is the last to overwrite.
    always_comb begin
        found_any   = |core_found;
        found_nonce = '0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            if (core_found[i]) begin
                found_nonce = core_nonce[32*i +: 32];
            end
        end
    end

    assign all_done = &(mask_q | core_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= '0;
        end else if (clear) begin
            mask_q <= '0;
        end else if (track) begin
            mask_q <= mask_q | core_done;
        end
    end

endmodule

// File: rtl/siacore_scheduler.sv
// ---------------------------------------------------------------------------
// siacore_scheduler
// Sequences the Sia hashing datapath. Accepts a work unit (640-bit header plus
// 32-bit target), loads NCORES siacore instances one per cycle with disjoint
// nonce ranges, then waits for the first found nonce or for every core to
// exhaust its range. All cores are aborted and one result is held for the
// UART response framer.
//
// Optional feature: define SIACORE_SCHED_TIMEOUT_EN to add a RUN watchdog of
// TIMEOUT_CYC cycles that reports status 10. Without it RUN waits forever.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   work_valid    new work pulse from the command parser
//   work_in       block header, nonce at [287:256] little-endian
//   target_in     difficulty target
//   work_ready    work_valid is accepted in this cycle when high
//   core_load     one-hot load pulse, core_work/core_target valid with it
//   core_work     shared work bus with the per-core nonce start inserted
//   core_target   shared target bus
//   core_abort    one-cycle stop pulse to every core
//   core_found    per-core found pulse
//   core_nonce    per-core nonce, core k at [32k+31:32k]
//   core_done     per-core range-exhausted pulse
//   res_valid     result available, held until res_ready
//   res_nonce     found nonce (0 when not found)
//   res_status    00 found, 01 exhausted, 10 timeout
//   res_ready     framer accepts the result
//   busy          scheduler is not idle
// ---------------------------------------------------------------------------
// state     | meaning
// ST_IDLE   | waiting for work, work_ready high
// ST_LOAD   | pulsing core_load for core k, one core per cycle
// ST_RUN    | cores hashing; watching found/done (and new work preempts)
// ST_REPORT | result held on res_*, waiting for res_ready
// ---------------------------------------------------------------------------
module siacore_scheduler
    import siacore_scheduler_pkg::*;
#(
    parameter int NCORES     = 4,
    parameter int RANGE_LOG2 = 30
`ifdef SIACORE_SCHED_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 32'd16777216
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   work_valid,
    input  logic [WORK_W-1:0]      work_in,
    input  logic [31:0]            target_in,
    output logic                   work_ready,
    output logic [NCORES-1:0]      core_load,
    output logic [WORK_W-1:0]      core_work,
    output logic [31:0]            core_target,
    output logic                   core_abort,
    input  logic [NCORES-1:0]      core_found,
    input  logic [NCORES*32-1:0]   core_nonce,
    input  logic [NCORES-1:0]      core_done,
    output logic                   res_valid,
    output logic [31:0]            res_nonce,
    output logic [1:0]             res_status,
    input  logic                   res_ready,
    output logic                   busy
);

    localparam logic [K_W-1:0] LAST_K = K_W'(NCORES - 1);

    logic [1:0]          state_q;
    logic [K_W-1:0]      k_q;
    logic [WORK_W-1:0]   work_q;
    logic [31:0]         target_q;
    logic [31:0]         base_q;
    logic                abort_q;
    sched_result_t       res_q;

    logic                load_last;
    logic                run_active;
    logic                found_any;
    logic [31:0]         found_nonce;
    logic                all_done;
    logic                timeout_hit;
    logic [31:0]         core_offset;

    assign load_last  = (state_q == ST_LOAD) && (k_q == LAST_K);
    assign run_active = (state_q == ST_RUN);

    siacore_scheduler_found_arb #(
        .NCORES (NCORES)
    ) u_found_arb (
        .clk         (clk),
        .rst         (rst),
        .clear       (load_last),
        .track       (run_active),
        .core_found  (core_found),
        .core_nonce  (core_nonce),
        .core_done   (core_done),
        .found_any   (found_any),
        .found_nonce (found_nonce),
        .all_done    (all_done)
    );

`ifdef SIACORE_SCHED_TIMEOUT_EN
    logic [31:0] tmo_cnt_q;

    // Counts RUN cycles from zero; the TIMEOUT_CYC-th RUN cycle fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else if (load_last) begin
            tmo_cnt_q <= '0;
        end else if (run_active) begin
            tmo_cnt_q <= tmo_cnt_q + 32'd1;
        end
    end

    assign timeout_hit = run_active && (tmo_cnt_q == TIMEOUT_CYC - 32'd1);
`else
    assign timeout_hit = 1'b0;
`endif

    // Core k starts at base + k * 2^RANGE_LOG2, wrapping at 32 bits, and the
    // header carries it back in little-endian byte order.
    assign core_offset = 32'(k_q) << RANGE_LOG2;

    always_comb begin
        core_work                      = work_q;
        core_work[NONCE_MSB:NONCE_LSB] = bswap32(base_q + core_offset);
    end

    assign core_load   = (state_q == ST_LOAD) ? (NCORES'(1) << k_q) : '0;
    assign core_target = target_q;
    assign core_abort  = abort_q;
    assign work_ready  = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign busy        = (state_q != ST_IDLE);
    assign res_valid   = (state_q == ST_REPORT);
    assign res_nonce   = res_q.nonce;
    assign res_status  = res_q.status;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            work_q   <= '0;
            target_q <= '0;
            base_q   <= '0;
            abort_q  <= 1'b0;
            res_q    <= '0;
        end else begin
            abort_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (work_valid) begin
                        work_q   <= work_in;
                        target_q <= target_in;
                        base_q   <= bswap32(work_in[NONCE_MSB:NONCE_LSB]);
                        k_q      <= '0;
                        state_q  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (k_q == LAST_K) begin
                        state_q <= ST_RUN;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    // New work preempts: any result from this cycle is dropped.
                    if (work_valid) begin
                        abort_q  <= 1'b1;
                        work_q   <= work_in;
                        target_q <= target_in;
                        base_q   <= bswap32(work_in[NONCE_MSB:NONCE_LSB]);
                        k_q      <= '0;
                        state_q  <= ST_LOAD;
                    end else if (found_any) begin
                        abort_q <= 1'b1;
                        res_q   <= '{nonce: found_nonce, status: RES_FOUND};
                        state_q <= ST_REPORT;
                    end else if (all_done) begin
                        abort_q <= 1'b1;
                        res_q   <= '{nonce: 32'd0, status: RES_EXHAUSTED};
                        state_q <= ST_REPORT;
                    end else if (timeout_hit) begin
                        abort_q <= 1'b1;
                        res_q   <= '{nonce: 32'd0, status: RES_TIMEOUT};
                        state_q <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    if (res_ready) begin
                        res_q   <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_siacore_scheduler.sv
module tb_siacore_scheduler;

    localparam int NC = 4;
    localparam int RL = 30;

    logic              clk = 1'b0;
    logic              rst;
    logic              work_valid;
    logic [639:0]      work_in;
    logic [31:0]       target_in;
    logic              work_ready;
    logic [NC-1:0]     core_load;
    logic [639:0]      core_work;
    logic [31:0]       core_target;
    logic              core_abort;
    logic [NC-1:0]     core_found;
    logic [NC*32-1:0]  core_nonce;
    logic [NC-1:0]     core_done;
    logic              res_valid;
    logic [31:0]       res_nonce;
    logic [1:0]        res_status;
    logic              res_ready;
    logic              busy;

    int total = 0;
    int bad   = 0;

    logic [639:0] cur_work;
    logic [31:0]  cur_target;

    always #5 clk = ~clk;

    siacore_scheduler #(
        .NCORES     (NC),
        .RANGE_LOG2 (RL)
`ifdef SIACORE_SCHED_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(100)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .work_valid  (work_valid),
        .work_in     (work_in),
        .target_in   (target_in),
        .work_ready  (work_ready),
        .core_load   (core_load),
        .core_work   (core_work),
        .core_target (core_target),
        .core_abort  (core_abort),
        .core_found  (core_found),
        .core_nonce  (core_nonce),
        .core_done   (core_done),
        .res_valid   (res_valid),
        .res_nonce   (res_nonce),
        .res_status  (res_status),
        .res_ready   (res_ready),
        .busy        (busy)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] swap_bytes(input logic [31:0] x);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = x[8*(3-b) +: 8];
        return r;
    endfunction

    // Expected little-endian nonce field for core k: base + k * 2^RL, mod 2^32.
    function automatic logic [31:0] core_field(input logic [31:0] base, input int k);
        logic [63:0] span;
        span = 64'(k) * (64'd1 << RL);
        return swap_bytes(base + span[31:0]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_exhaust();
        core_done = '1;
        step();
        core_done = '0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic load_and_check(input logic [31:0] base, input logic expect_abort, input string tag);
        logic [639:0]   exp_work;
        logic [NC-1:0]  exp_load;
        for (int w = 0; w < 20; w++) cur_work[32*w +: 32] = $urandom;
        cur_work[287:256] = swap_bytes(base);
        cur_target = $urandom;
        total++;
        if (work_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_before_work: got %b want 1", tag, work_ready);
        end
        work_in    = cur_work;
        target_in  = cur_target;
        work_valid = 1'b1;
        step();
        work_valid = 1'b0;
        core_found = '0;
        core_done  = '0;
        work_in    = ~cur_work;
        target_in  = ~cur_target;
        for (int k = 0; k < NC; k++) begin
            exp_load = NC'(1) << k;
            exp_work = cur_work;
            exp_work[287:256] = core_field(base, k);
            total++;
            if (core_load !== exp_load) begin
                bad++;
                $display("FAIL %s load_onehot k=%0d: got %b want %b", tag, k, core_load, exp_load);
            end
            total++;
            if (core_work[287:256] !== exp_work[287:256]) begin
                bad++;
                $display("FAIL %s nonce_field k=%0d: got %h want %h", tag, k, core_work[287:256], exp_work[287:256]);
            end
            total++;
            if (core_work !== exp_work) begin
                bad++;
                $display("FAIL %s header_bits k=%0d: got diff %h want diff 0", tag, k, core_work ^ exp_work);
            end
            total++;
            if (core_target !== cur_target) begin
                bad++;
                $display("FAIL %s target k=%0d: got %h want %h", tag, k, core_target, cur_target);
            end
            total++;
            if (core_abort !== ((k == 0) ? expect_abort : 1'b0)) begin
                bad++;
                $display("FAIL %s abort_in_load k=%0d: got %b want %b", tag, k, core_abort, (k == 0) ? expect_abort : 1'b0);
            end
            total++;
            if ({work_ready, busy, res_valid} !== 3'b010) begin
                bad++;
                $display("FAIL %s load_flags k=%0d: got %b want 010", tag, k, {work_ready, busy, res_valid});
            end
            step();
        end
        total++;
        if ({core_load, work_ready, busy, res_valid, core_abort} !== {{NC{1'b0}}, 4'b1100}) begin
            bad++;
            $display("FAIL %s run_entry: got %b want %b", tag, {core_load, work_ready, busy, res_valid, core_abort}, {{NC{1'b0}}, 4'b1100});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        work_valid = 1'b0; work_in = '0; target_in = '0;
        core_found = '0; core_nonce = '0; core_done = '0; res_ready = 1'b0;
        step();
        step();
        total++;
        if ({work_ready, busy, core_abort, res_valid} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 1000", {work_ready, busy, core_abort, res_valid});
        end
        total++;
        if (core_load !== '0 || core_work !== '0 || core_target !== '0) begin
            bad++;
            $display("FAIL reset_core_bus: got load=%b field=%h target=%h want zeros", core_load, core_work[287:256], core_target);
        end
        total++;
        if ({res_nonce, res_status} !== 34'd0) begin
            bad++;
            $display("FAIL reset_result: got %h/%b want 0/00", res_nonce, res_status);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        total++;
        if ({work_ready, busy} !== 2'b10) begin
            bad++;
            $display("FAIL idle_after_reset: got %b want 10", {work_ready, busy});
        end
    endtask

    task automatic test_load_fields();
        load_and_check(32'h00000010, 1'b0, "load_base10");
        drain_exhaust();
        load_and_check(32'hF0000001, 1'b0, "load_wrap");
        drain_exhaust();
    endtask

    task automatic test_found();
        logic [31:0] nn [NC];
        load_and_check($urandom, 1'b0, "found");
        step();
        step();
        for (int i = 0; i < NC; i++) nn[i] = $urandom;
        nn[2] = 32'h1234ABCD;
        for (int i = 0; i < NC; i++) core_nonce[32*i +: 32] = nn[i];
        core_found = 4'b0100;
        step();
        core_found = '0;
        total++;
        if ({core_abort, res_valid, work_ready} !== 3'b110) begin
            bad++;
            $display("FAIL found_flags: got %b want 110", {core_abort, res_valid, work_ready});
        end
        total++;
        if (res_nonce !== 32'h1234ABCD || res_status !== 2'b00) begin
            bad++;
            $display("FAIL found_result: got %h/%b want 1234abcd/00", res_nonce, res_status);
        end
        for (int c = 0; c < 5; c++) begin
            core_found = NC'($urandom);
            core_done  = NC'($urandom);
            core_nonce = {NC{$urandom}};
            step();
            total++;
            if ({core_abort, res_valid} !== 2'b01 || res_nonce !== 32'h1234ABCD || res_status !== 2'b00) begin
                bad++;
                $display("FAIL found_hold c=%0d: got abort=%b valid=%b %h/%b want 0 1 1234abcd/00", c, core_abort, res_valid, res_nonce, res_status);
            end
        end
        core_found = '0;
        core_done  = '0;
        res_ready  = 1'b1;
        step();
        res_ready  = 1'b0;
        total++;
        if ({res_valid, busy, work_ready} !== 3'b001) begin
            bad++;
            $display("FAIL found_accept: got %b want 001", {res_valid, busy, work_ready});
        end
    endtask

    task automatic test_tie();
        logic [31:0] nn [NC];
        load_and_check($urandom, 1'b0, "tie");
        for (int i = 0; i < NC; i++) nn[i] = $urandom;
        for (int i = 0; i < NC; i++) core_nonce[32*i +: 32] = nn[i];
        core_found = 4'b1010;
        step();
        core_found = '0;
        total++;
        if (res_valid !== 1'b1 || res_nonce !== nn[1] || res_status !== 2'b00) begin
            bad++;
            $display("FAIL tie_lowest: got valid=%b %h/%b want 1 %h/00", res_valid, res_nonce, res_status, nn[1]);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_exhaust();
        logic [NC-1:0] pat [6];
        pat = '{4'b0001, 4'b0000, 4'b0001, 4'b0100, 4'b1000, 4'b0010};
        load_and_check($urandom, 1'b0, "exhaust");
        for (int c = 0; c < 6; c++) begin
            core_done = pat[c];
            step();
            core_done = '0;
            if (c < 5) begin
                total++;
                if ({core_abort, res_valid, busy} !== 3'b001) begin
                    bad++;
                    $display("FAIL exhaust_early c=%0d: got %b want 001", c, {core_abort, res_valid, busy});
                end
            end
        end
        total++;
        if ({core_abort, res_valid} !== 2'b11 || res_nonce !== 32'd0 || res_status !== 2'b01) begin
            bad++;
            $display("FAIL exhaust_result: got abort=%b valid=%b %h/%b want 1 1 0/01", core_abort, res_valid, res_nonce, res_status);
        end
        step();
        total++;
        if ({core_abort, res_valid} !== 2'b01) begin
            bad++;
            $display("FAIL exhaust_single_abort: got %b want 01", {core_abort, res_valid});
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_found_vs_done();
        logic [31:0] n3;
        load_and_check($urandom, 1'b0, "found_vs_done");
        core_done = 4'b0111;
        step();
        n3 = $urandom;
        core_nonce = '0;
        core_nonce[96 +: 32] = n3;
        core_found = 4'b1000;
        core_done  = 4'b1000;
        step();
        core_found = '0;
        core_done  = '0;
        total++;
        if (res_valid !== 1'b1 || res_nonce !== n3 || res_status !== 2'b00) begin
            bad++;
            $display("FAIL found_beats_done: got valid=%b %h/%b want 1 %h/00", res_valid, res_nonce, res_status, n3);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_preempt();
        load_and_check(32'h00000100, 1'b0, "preempt_first");
        core_done = 4'b0011;
        step();
        core_done = '0;
        step();
        step();
        core_found = 4'b0001;
        core_nonce = {NC{$urandom}};
        load_and_check(32'hABCD0000, 1'b1, "preempt_replay");
        core_done = 4'b1110;
        step();
        core_done = '0;
        total++;
        if ({res_valid, busy, core_abort} !== 3'b010) begin
            bad++;
            $display("FAIL preempt_mask_fresh: got %b want 010", {res_valid, busy, core_abort});
        end
        drain_exhaust();
    endtask

    task automatic test_random();
        bit            seen [NC];
        logic [31:0]   nn [NC];
        logic [NC-1:0] fv, dv;
        logic [31:0]   exp_nonce;
        logic [1:0]    exp_status;
        bit            fin, all;
        int            cyc, hold;
        for (int it = 0; it < 15; it++) begin
            load_and_check($urandom, 1'b0, "random");
            for (int i = 0; i < NC; i++) seen[i] = 1'b0;
            fin = 1'b0;
            cyc = 0;
            exp_nonce = '0;
            exp_status = '0;
            while (!fin) begin
                fv = ($urandom_range(0, 9) == 0) ? NC'($urandom_range(1, 15)) : '0;
                dv = NC'($urandom) & NC'($urandom);
                if (cyc >= 40) dv = '1;
                for (int i = 0; i < NC; i++) nn[i] = $urandom;
                for (int i = 0; i < NC; i++) core_nonce[32*i +: 32] = nn[i];
                core_found = fv;
                core_done  = dv;
                if (fv != '0) begin
                    fin = 1'b1;
                    exp_status = 2'b00;
                    for (int i = NC - 1; i >= 0; i--) if (fv[i]) exp_nonce = nn[i];
                end else begin
                    all = 1'b1;
                    for (int i = 0; i < NC; i++) begin
                        if (dv[i]) seen[i] = 1'b1;
                        if (!seen[i]) all = 1'b0;
                    end
                    if (all) begin
                        fin = 1'b1;
                        exp_status = 2'b01;
                        exp_nonce = 32'd0;
                    end
                end
                step();
                core_found = '0;
                core_done  = '0;
                cyc++;
                total++;
                if (!fin) begin
                    if ({core_abort, res_valid} !== 2'b00) begin
                        bad++;
                        $display("FAIL random_early it=%0d cyc=%0d: got %b want 00", it, cyc, {core_abort, res_valid});
                    end
                end else if ({core_abort, res_valid} !== 2'b11 || res_nonce !== exp_nonce || res_status !== exp_status) begin
                    bad++;
                    $display("FAIL random_result it=%0d cyc=%0d: got %b %h/%b want 11 %h/%b", it, cyc, {core_abort, res_valid}, res_nonce, res_status, exp_nonce, exp_status);
                end
            end
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) step();
            res_ready = 1'b1;
            step();
            res_ready = 1'b0;
            total++;
            if ({busy, res_valid} !== 2'b00) begin
                bad++;
                $display("FAIL random_idle it=%0d: got %b want 00", it, {busy, res_valid});
            end
        end
    endtask

    task automatic test_reset_mid_load();
        work_in = '1;
        target_in = $urandom;
        work_valid = 1'b1;
        step();
        work_valid = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (core_load !== '0 || {busy, work_ready, core_abort, res_valid} !== 4'b0100) begin
            bad++;
            $display("FAIL rst_mid_load: got load=%b flags=%b want 0 0100", core_load, {busy, work_ready, core_abort, res_valid});
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        total++;
        if (core_load !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_stays_idle: got load=%b busy=%b want 0 0", core_load, busy);
        end
        load_and_check(32'h7FFFFFFF, 1'b0, "after_rst");
        drain_exhaust();
    endtask

`ifdef SIACORE_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        load_and_check($urandom, 1'b0, "timeout");
        for (int i = 1; i <= 100; i++) begin
            step();
            if (i < 100) begin
                if ({core_abort, res_valid} !== 2'b00) begin
                    total++;
                    bad++;
                    $display("FAIL timeout_early i=%0d: got %b want 00", i, {core_abort, res_valid});
                end
            end else begin
                total++;
                if ({core_abort, res_valid} !== 2'b11 || res_nonce !== 32'd0 || res_status !== 2'b10) begin
                    bad++;
                    $display("FAIL timeout_result: got %b %h/%b want 11 0/10", {core_abort, res_valid}, res_nonce, res_status);
                end
            end
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_load_fields();
        test_found();
        test_tie();
        test_exhaust();
        test_found_vs_done();
        test_preempt();
        test_random();
        test_reset_mid_load();
`ifdef SIACORE_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
